// File: rtl/irq_dispatch_ctrl.sv
// SM83 interrupt dispatch sequencer: pushes PC, clears the serviced IF
// bit and IME, then jumps to the vector of the highest-priority source.

package irq_dispatch_pkg;

    typedef enum logic [3:0] {
        REG_A   = 4'd0,
        REG_F   = 4'd1,
        REG_B   = 4'd2,
        REG_C   = 4'd3,
        REG_D   = 4'd4,
        REG_E   = 4'd5,
        REG_H   = 4'd6,
        REG_L   = 4'd7,
        REG_SPH = 4'd8,
        REG_SPL = 4'd9,
        REG_PCH = 4'd10,
        REG_PCL = 4'd11
    } register_n_t;

    typedef enum logic [2:0] {
        REG_AF = 3'd0,
        REG_BC = 3'd1,
        REG_DE = 3'd2,
        REG_HL = 3'd3,
        REG_SP = 3'd4,
        REG_PC = 3'd5
    } register_nn_t;

endpackage

module irq_dispatch_ctrl
    import irq_dispatch_pkg::*;
#(
    parameter int          N_IRQ      = 5,
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter int          VEC_STRIDE = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_boundary,
    input  logic               ime,
    input  logic [N_IRQ-1:0]   ie,
    input  logic [N_IRQ-1:0]   if_,
    output logic               busy,
    output logic               done,
    output logic               halt_wake,
    output logic [N_IRQ-1:0]   if_clear,
    output logic               ime_clear,
    output logic               rf_read_r,
    output register_n_t        rf_read_reg_r,
    input  logic [7:0]         rf_data_r,
    output logic               rf_read_rr,
    output register_nn_t       rf_read_reg_rr,
    input  logic [15:0]        rf_data_rr,
    output logic               rf_write_rr,
    output register_nn_t       rf_write_reg_rr,
    output logic [15:0]        rf_data_in_rr,
    output logic               mem_we,
    output logic [15:0]        mem_addr,
    output logic [7:0]         mem_wdata,
    input  logic               mem_ack
);

    localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_DEC_H  = 3'd2,
        S_PUSH_H = 3'd3,
        S_DEC_L  = 3'd4,
        S_PUSH_L = 3'd5,
        S_JUMP   = 3'd6
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           cancel_q, cancel_d;

    logic [N_IRQ-1:0] pend;
    logic [IW-1:0]    sel;
    logic [15:0]      vec;

    assign pend      = ie & if_;
    assign halt_wake = |pend;
    assign vec       = VEC_BASE + (16'(VEC_STRIDE) * 16'(idx_q));

    // Priority encoder: lowest set pending bit wins.
    always_comb begin
        sel = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel = IW'(i);
            end
        end
    end

    // State, latched source index and cancel flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cancel_q <= cancel_d;
        end
    end

    // Sequencing; the PUSH_H ack is the only point that looks at IE/IF again.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cancel_d = cancel_q;
        unique case (state_q)
            S_IDLE: begin
                if (instr_boundary && ime && (|pend)) begin
                    idx_d    = sel;
                    cancel_d = 1'b0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT:  state_d = S_DEC_H;
            S_DEC_H: state_d = S_PUSH_H;
            S_PUSH_H: begin
                if (mem_ack) begin
                    if (pend == '0) begin
                        cancel_d = 1'b1;
                    end else begin
                        idx_d = sel;
                    end
                    state_d = S_DEC_L;
                end
            end
            S_DEC_L: state_d = S_PUSH_L;
            S_PUSH_L: begin
                if (mem_ack) begin
                    state_d = S_JUMP;
                end
            end
            S_JUMP: begin
                cancel_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Port drive per state; everything idles at zero outside its use.
    always_comb begin
        busy            = (state_q != S_IDLE);
        done            = 1'b0;
        if_clear        = '0;
        ime_clear       = 1'b0;
        rf_read_r       = 1'b0;
        rf_read_reg_r   = REG_A;
        rf_read_rr      = 1'b0;
        rf_read_reg_rr  = REG_AF;
        rf_write_rr     = 1'b0;
        rf_write_reg_rr = REG_AF;
        rf_data_in_rr   = 16'h0000;
        mem_we          = 1'b0;
        mem_addr        = 16'h0000;
        mem_wdata       = 8'h00;
        unique case (state_q)
            S_DEC_H, S_DEC_L: begin
                rf_read_rr      = 1'b1;
                rf_read_reg_rr  = REG_SP;
                rf_write_rr     = 1'b1;
                rf_write_reg_rr = REG_SP;
                rf_data_in_rr   = rf_data_rr - 16'd1;
            end
            S_PUSH_H, S_PUSH_L: begin
                rf_read_rr     = 1'b1;
                rf_read_reg_rr = REG_SP;
                rf_read_r      = 1'b1;
                rf_read_reg_r  = (state_q == S_PUSH_H) ? REG_PCH : REG_PCL;
                mem_we         = 1'b1;
                mem_addr       = rf_data_rr;
                mem_wdata      = rf_data_r;
            end
            S_JUMP: begin
                rf_write_rr     = 1'b1;
                rf_write_reg_rr = REG_PC;
                rf_data_in_rr   = cancel_q ? 16'h0000 : vec;
                ime_clear       = 1'b1;
                done            = 1'b1;
                if_clear        = cancel_q ? '0 : (N_IRQ'(1) << idx_q);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_irq_dispatch_ctrl.sv
// Randomised scoreboard bench for irq_dispatch_ctrl with an RF/memory
// model around the DUT and a monitor that retires expected events.

module tb_irq_dispatch_ctrl;
    import irq_dispatch_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         instr_boundary = 1'b0;
    logic         ime = 1'b0;
    logic [4:0]   ie = '0;
    logic [4:0]   if_ = '0;
    logic         busy, done, halt_wake, ime_clear;
    logic [4:0]   if_clear;
    logic         rf_read_r, rf_read_rr, rf_write_rr;
    register_n_t  rf_read_reg_r;
    register_nn_t rf_read_reg_rr, rf_write_reg_rr;
    logic [7:0]   rf_data_r;
    logic [15:0]  rf_data_rr, rf_data_in_rr;
    logic         mem_we, mem_ack = 1'b0;
    logic [15:0]  mem_addr;
    logic [7:0]   mem_wdata;

    int checks = 0;
    int errors = 0;

    logic [15:0] sp_m = 16'h0000;
    logic [15:0] pc_m = 16'h0000;
    int ack_dh = 0;
    int ack_dl = 0;

    typedef struct {
        bit          is_jmp;
        logic [15:0] a;
        logic [7:0]  d;
        logic [15:0] pc;
        logic [4:0]  ifc;
        int          lat;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    irq_dispatch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_boundary(instr_boundary),
        .ime(ime), .ie(ie), .if_(if_), .busy(busy), .done(done),
        .halt_wake(halt_wake), .if_clear(if_clear), .ime_clear(ime_clear),
        .rf_read_r(rf_read_r), .rf_read_reg_r(rf_read_reg_r),
        .rf_data_r(rf_data_r), .rf_read_rr(rf_read_rr),
        .rf_read_reg_rr(rf_read_reg_rr), .rf_data_rr(rf_data_rr),
        .rf_write_rr(rf_write_rr), .rf_write_reg_rr(rf_write_reg_rr),
        .rf_data_in_rr(rf_data_in_rr), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack)
    );

    assign rf_data_r  = !rf_read_r ? 8'h00 :
                        (rf_read_reg_r == REG_PCH) ? pc_m[15:8] :
                        (rf_read_reg_r == REG_PCL) ? pc_m[7:0] : 8'hEE;
    assign rf_data_rr = (rf_read_rr && rf_read_reg_rr == REG_SP) ? sp_m : 16'h0000;

    // Register file write port: capture mid-cycle, commit on the edge.
    initial begin
        logic we; register_nn_t r; logic [15:0] d;
        forever begin
            @(negedge clk);
            we = rf_write_rr; r = rf_write_reg_rr; d = rf_data_in_rr;
            @(posedge clk);
            if (we && r == REG_SP) sp_m = d;
            if (we && r == REG_PC) pc_m = d;
        end
    end

    // Memory responder with per-push ack delay and stray acks elsewhere.
    initial begin
        int wcnt; int dly;
        wcnt = 0;
        forever begin
            @(posedge clk); #1;
            if (mem_we) begin
                dly = (rf_read_reg_r == REG_PCH) ? ack_dh : ack_dl;
                mem_ack = (wcnt >= dly);
                wcnt = mem_ack ? 0 : wcnt + 1;
            end else begin
                mem_ack = 1'($urandom % 2);
                wcnt = 0;
            end
        end
    end

    // Monitor: retire expected events, check handshake invariants.
    initial begin
        exp_t e; int bcnt; logic pwe, pack; logic [15:0] pa; logic [7:0] pd;
        bcnt = 0; pwe = 0; pack = 0; pa = 0; pd = 0;
        forever begin
            @(negedge clk);
            checks++;
            if (halt_wake !== |(ie & if_)) begin
                errors++;
                $display("FAIL halt_wake got=%b exp=%b", halt_wake, |(ie & if_));
            end
            if (rf_write_rr && mem_we) begin
                errors++;
                $display("FAIL excl rf_write_rr and mem_we both high");
            end
            if (pwe && !pack && rst_n) begin
                checks++;
                if (!mem_we || mem_addr !== pa || mem_wdata !== pd) begin
                    errors++;
                    $display("FAIL hold we=%b addr=%h/%h data=%h/%h",
                             mem_we, mem_addr, pa, mem_wdata, pd);
                end
            end
            if ((|if_clear || ime_clear) && !done) begin
                errors++;
                $display("FAIL clr_pulse if_clear=%b ime_clear=%b without done",
                         if_clear, ime_clear);
            end
            bcnt = busy ? bcnt + 1 : 0;
            if (mem_we && mem_ack) begin
                checks++;
                if (q.size() == 0 || q[0].is_jmp) begin
                    errors++;
                    $display("FAIL memwr unexpected [%h]=%h", mem_addr, mem_wdata);
                end else begin
                    e = q.pop_front();
                    if (mem_addr !== e.a || mem_wdata !== e.d) begin
                        errors++;
                        $display("FAIL memwr got [%h]=%h exp [%h]=%h",
                                 mem_addr, mem_wdata, e.a, e.d);
                    end
                end
            end
            if (done) begin
                checks++;
                if (q.size() == 0 || !q[0].is_jmp) begin
                    errors++;
                    $display("FAIL jump unexpected done data=%h", rf_data_in_rr);
                end else begin
                    e = q.pop_front();
                    if (!rf_write_rr || rf_write_reg_rr != REG_PC ||
                        rf_data_in_rr !== e.pc || if_clear !== e.ifc ||
                        !ime_clear || bcnt != e.lat) begin
                        errors++;
                        $display("FAIL jump pc=%h/%h ifc=%b/%b imec=%b busy=%0d/%0d",
                                 rf_data_in_rr, e.pc, if_clear, e.ifc,
                                 ime_clear, bcnt, e.lat);
                    end
                end
            end
            pwe = mem_we; pack = mem_ack; pa = mem_addr; pd = mem_wdata;
        end
    end

    function automatic logic outs_nonzero();
        return busy | done | ime_clear | rf_read_r | rf_read_rr |
               rf_write_rr | mem_we | (|if_clear) | (|mem_addr) |
               (|mem_wdata) | (|rf_data_in_rr) | (|rf_read_reg_r) |
               (|rf_read_reg_rr) | (|rf_write_reg_rr);
    endfunction

    function automatic int lowest(input logic [4:0] p);
        for (int i = 0; i < 5; i++) if (p[i]) return i;
        return -1;
    endfunction

    // mode 0: IF held; 1: IF cleared before PUSH_H ack; 2: IF replaced.
    task automatic dispatch(input logic [15:0] sp0, input logic [15:0] pc0,
                            input logic [4:0] iev, input logic [4:0] ifv,
                            input int dh, input int dl, input int mode,
                            input logic [4:0] ifn);
        exp_t e; logic [4:0] p2; logic [15:0] pcx; bit seen, fin;
        int s;
        sp_m = sp0; pc_m = pc0; ack_dh = dh; ack_dl = dl;
        ie = iev; if_ = ifv; ime = 1'b1; instr_boundary = 1'b1;
        e = '{0, sp0 - 16'd1, pc0[15:8], 16'h0, 5'h0, 0}; q.push_back(e);
        e = '{0, sp0 - 16'd2, pc0[7:0], 16'h0, 5'h0, 0}; q.push_back(e);
        p2 = iev & ((mode == 0) ? ifv : (mode == 1) ? 5'h00 : ifn);
        s = lowest(p2);
        pcx = (s < 0) ? 16'h0000 : 16'h0040 + 16'(8 * s);
        e = '{1, 16'h0, 8'h0, pcx, (s < 0) ? 5'h00 : 5'(1 << s), 6 + dh + dl};
        q.push_back(e);
        @(posedge clk); #2;
        instr_boundary = 1'b0;
        seen = 0; fin = 0;
        for (int n = 0; n < 40 && !fin; n++) begin
            @(posedge clk); #2;
            if (!seen && mem_we) begin
                seen = 1;
                if (mode == 1) if_ = 5'h00;
                if (mode == 2) if_ = ifn;
            end
            if (done) begin
                fin = 1; ime = 1'b0; instr_boundary = 1'b0;
            end else begin
                instr_boundary = 1'($urandom); ime = 1'($urandom);
            end
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL timeout no done within 40 cycles");
            q.delete();
            ime = 1'b0; instr_boundary = 1'b0;
        end
        @(posedge clk); #2;
        checks++;
        if (sp_m !== sp0 - 16'd2 || pc_m !== pcx || busy) begin
            errors++;
            $display("FAIL final sp=%h/%h pc=%h/%h busy=%b",
                     sp_m, sp0 - 16'd2, pc_m, pcx, busy);
        end
        ie = '0; if_ = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic reset_abort(input logic [15:0] sp0, input logic [15:0] pc0);
        bit hit;
        exp_t e;
        sp_m = sp0; pc_m = pc0; ack_dh = 0; ack_dl = 30;
        ie = 5'h1F; if_ = 5'h08; ime = 1'b1; instr_boundary = 1'b1;
        e = '{0, sp0 - 16'd1, pc0[15:8], 16'h0, 5'h0, 0}; q.push_back(e);
        @(posedge clk); #2;
        instr_boundary = 1'b0; ime = 1'b0;
        hit = 0;
        for (int n = 0; n < 30 && !hit; n++) begin
            @(posedge clk); #2;
            if (mem_we && rf_read_reg_r == REG_PCL) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rst_reach never entered PUSH_L");
        end
        rst_n = 1'b0; #1;
        checks++;
        if (outs_nonzero()) begin
            errors++;
            $display("FAIL rst_abort outputs busy=%b we=%b wr=%b addr=%h",
                     busy, mem_we, rf_write_rr, mem_addr);
        end
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        checks++;
        if (pc_m !== pc0 || sp_m !== sp0 - 16'd2 || busy) begin
            errors++;
            $display("FAIL rst_after pc=%h/%h sp=%h/%h busy=%b",
                     pc_m, pc0, sp_m, sp0 - 16'd2, busy);
        end
        ie = '0; if_ = '0; ack_dl = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        bit bad;
        logic [4:0] r_ie, r_if, r_n;
        ie = 5'h03; if_ = 5'h01;
        #3;
        checks++;
        if (outs_nonzero() || !halt_wake) begin
            errors++;
            $display("FAIL reset outputs nonzero or halt_wake=%b", halt_wake);
        end
        ie = '0; if_ = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        dispatch(16'hFFFE, 16'h1234, 5'h1F, 5'h04, 0, 0, 0, 5'h00);
        dispatch(16'hC000, 16'h0150, 5'h1F, 5'h1F, 0, 0, 0, 5'h00);
        dispatch(16'hC000, 16'h0150, 5'h10, 5'h10, 0, 0, 0, 5'h00);
        dispatch(16'hDFF0, 16'hABCD, 5'h1F, 5'h04, 0, 0, 1, 5'h00);
        dispatch(16'hDFF0, 16'h4321, 5'h1F, 5'h04, 3, 0, 0, 5'h00);
        dispatch(16'h0000, 16'h9876, 5'h1F, 5'h02, 0, 1, 0, 5'h00);
        dispatch(16'hFF80, 16'h2000, 5'h1F, 5'h04, 0, 0, 2, 5'h12);

        ime = 1'b0; ie = 5'h01; if_ = 5'h01; instr_boundary = 1'b1;
        @(posedge clk); #2 instr_boundary = 1'b0;
        bad = 0;
        repeat (8) begin
            @(posedge clk); #2;
            if (busy || !halt_wake) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL noime busy=%b halt_wake=%b exp busy=0 wake=1",
                     busy, halt_wake);
        end
        ie = '0; if_ = '0;
        @(posedge clk); #1;

        reset_abort(16'hD000, 16'h5A5A);

        for (int k = 0; k < 30; k++) begin
            r_ie = 5'($urandom);
            r_if = 5'($urandom);
            if ((r_ie & r_if) == 0) begin
                r_ie = r_ie | 5'h08; r_if = r_if | 5'h08;
            end
            r_n = 5'($urandom);
            dispatch(16'($urandom), 16'($urandom), r_ie, r_if,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)), r_n);
        end

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover %0d expected events not seen", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
